// File: rtl/mb_stage_align.sv
// mb_stage_align: LATENCY-deep message delay line kept in lock-step with a
// fixed-latency core, merging the core result lanes with a per-lane hold.
// Ports: in_* upstream valid/ready and payload; core_en/core_start drive
// the core, core_valid/core_res come back from it; out_* downstream record
// with valid/ready; inflight counts held tokens; align_err is sticky.
module mb_stage_align #(
  parameter int LATENCY = 29,
  parameter int MSG_W = 512,
  parameter int RES_W = 32,
  parameter int NRES = 2,
  parameter logic [NRES-1:0] HOLD_MASK = NRES'(1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MSG_W-1:0]              in_msg,
  input  logic                          in_hold,
  input  logic [NRES*RES_W-1:0]         in_old,
  output logic                          core_en,
  output logic                          core_start,
  input  logic                          core_valid,
  input  logic [NRES*RES_W-1:0]         core_res,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MSG_W-1:0]              out_msg,
  output logic                          out_hold,
  output logic [NRES*RES_W-1:0]         out_res,
  output logic [$clog2(LATENCY+2)-1:0]  inflight,
  output logic                          align_err
);

  localparam int RW = NRES * RES_W;
  localparam int CW = $clog2(LATENCY + 2);
  localparam int LAST = LATENCY - 1;

  logic               adv;
  logic               drain;
  logic [LATENCY-1:0] s_valid;
  logic [LATENCY-1:0] s_hold;
  logic [MSG_W-1:0]   s_msg [LATENCY];
  logic [RW-1:0]      s_old [LATENCY];
  logic [RW-1:0]      merged;

  // Global stall: nothing moves while the output is held.
  assign adv        = !out_valid || out_ready;
  assign drain      = out_valid && out_ready;
  assign in_ready   = adv;
  assign core_en    = adv;
  assign core_start = in_valid && adv;

  always_comb begin
    merged = core_res;
    for (int i = 0; i < NRES; i++) begin
      if (HOLD_MASK[i] && s_hold[LAST])
        merged[i*RES_W +: RES_W] =
          s_old[LAST][i*RES_W +: RES_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid   <= '0;
      out_valid <= 1'b0;
    end else if (adv) begin
      s_valid[0] <= in_valid;
      for (int k = 1; k < LATENCY; k++)
        s_valid[k] <= s_valid[k-1];
      out_valid <= s_valid[LAST];
    end
  end

  // Payload registers are not reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (adv) begin
      s_msg[0]  <= in_msg;
      s_hold[0] <= in_hold;
      s_old[0]  <= in_old;
      for (int k = 1; k < LATENCY; k++) begin
        s_msg[k]  <= s_msg[k-1];
        s_hold[k] <= s_hold[k-1];
        s_old[k]  <= s_old[k-1];
      end
      if (s_valid[LAST]) begin
        out_msg  <= s_msg[LAST];
        out_hold <= s_hold[LAST];
        out_res  <= merged;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      unique case ({core_start, drain})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // core_valid only feeds this checker, never the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      align_err <= 1'b0;
    else if (adv && (core_valid != s_valid[LAST]))
      align_err <= 1'b1;
  end

endmodule

// File: tb/tb_mb_stage_align.sv
// tb_mb_stage_align: scoreboard bench for mb_stage_align with a
// behavioural core model, random stimulus and directed corner cases.
module tb_mb_stage_align;

  localparam int L  = 29;
  localparam int MW = 512;
  localparam int RW = 32;
  localparam int NR = 2;
  localparam int TW = NR * RW;
  localparam int CW = $clog2(L + 2);
  localparam logic [NR-1:0] HM = 2'b01;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready;
  logic [MW-1:0] in_msg;
  logic          in_hold;
  logic [TW-1:0] in_old;
  logic          core_en, core_start, core_valid;
  logic [TW-1:0] core_res;
  logic          out_valid, out_ready;
  logic [MW-1:0] out_msg;
  logic          out_hold;
  logic [TW-1:0] out_res;
  logic [CW-1:0] inflight;
  logic          align_err;

  always #5 clk = ~clk;

  mb_stage_align #(
    .LATENCY(L), .MSG_W(MW), .RES_W(RW),
    .NRES(NR), .HOLD_MASK(HM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_msg(in_msg), .in_hold(in_hold),
    .in_old(in_old),
    .core_en(core_en), .core_start(core_start),
    .core_valid(core_valid), .core_res(core_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_msg(out_msg), .out_hold(out_hold),
    .out_res(out_res),
    .inflight(inflight), .align_err(align_err)
  );

  typedef struct {
    logic [MW-1:0] msg;
    logic          hold;
    logic [TW-1:0] res;
    int            cyc;
    int            st;
    bit            late;
  } exp_t;

  exp_t q[$];
  exp_t ie, me;
  int   checks = 0, fails = 0;
  int   cyc = 0, stalls = 0, peak = 0, st0 = 0;
  bit   seen = 0, err_exp = 0, rnd_rdy = 0;
  bit   adv_e;

  logic [TW-1:0] tok_res;
  bit            tok_late;
  bit            cap_en = 0, cap_v = 0, cap_late = 0;
  logic [TW-1:0] cap_res;

  logic          cp_v [L];
  logic          cp_l [L];
  logic [TW-1:0] cp_r [L];
  logic          late_d;

  task automatic chk(input string nm,
                     input logic [MW-1:0] a,
                     input logic [MW-1:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  function automatic logic [MW-1:0] rnd_msg();
    logic [MW-1:0] r;
    for (int i = 0; i < MW / 32; i++)
      r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Merge rule: masked lanes keep their old value on hold.
  function automatic logic [TW-1:0] model(
    input logic h, input logic [TW-1:0] o,
    input logic [TW-1:0] r);
    logic [TW-1:0] m;
    for (int i = 0; i < NR; i++)
      m[i*RW +: RW] = (HM[i] && h) ?
        o[i*RW +: RW] : r[i*RW +: RW];
    return m;
  endfunction

  // External core: fixed L-cycle pipe advancing on core_en.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < L; k++) begin
        cp_v[k] <= 1'b0;
        cp_l[k] <= 1'b0;
      end
      late_d <= 1'b0;
    end else if (cap_en) begin
      cp_v[0] <= cap_v;
      cp_l[0] <= cap_late;
      cp_r[0] <= cap_res;
      for (int k = 1; k < L; k++) begin
        cp_v[k] <= cp_v[k-1];
        cp_l[k] <= cp_l[k-1];
        cp_r[k] <= cp_r[k-1];
      end
      late_d <= cp_v[L-1] && cp_l[L-1];
    end
  end

  assign core_valid = (cp_v[L-1] && !cp_l[L-1]) || late_d;
  assign core_res   = cp_r[L-1];

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Issue side: push expectation when a token is accepted.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && in_valid && in_ready) begin
      ie.msg  = in_msg;
      ie.hold = in_hold;
      ie.res  = model(in_hold, in_old, tok_res);
      ie.cyc  = cyc;
      ie.st   = stalls;
      ie.late = tok_late;
      q.push_back(ie);
    end
    cap_en   = core_en;
    cap_v    = core_start;
    cap_res  = tok_res;
    cap_late = tok_late;
  end

  // Monitor: compare DUT output against queue front.
  always begin
    @(negedge clk);
    if (rst_n) begin
      adv_e = !out_valid || out_ready;
      chk("in_ready", in_ready, adv_e);
      chk("core_en", core_en, adv_e);
      chk("core_start", core_start, in_valid && adv_e);
      chk("inflight", inflight, q.size());
      if (int'(inflight) > peak) peak = int'(inflight);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("out_valid", out_valid, 0);
        end else begin
          me = q[0];
          if (!seen) begin
            chk("latency",
                cyc - me.cyc - (stalls - me.st), L + 1);
            seen = 1;
            if (me.late) err_exp = 1;
          end
          chk("out_msg", out_msg, me.msg);
          chk("out_hold", out_hold, me.hold);
          chk("out_res", out_res, me.res);
          if (out_ready) begin
            void'(q.pop_front());
            seen = 0;
          end
        end
      end else if (q.size() > 0 &&
          cyc - q[0].cyc - (stalls - q[0].st) >= L + 1) begin
        chk("out_valid", out_valid, 1);
        void'(q.pop_front());
        seen = 0;
      end
      chk("align_err", align_err, err_exp);
      if (out_valid && !out_ready) stalls++;
    end
  end

  task automatic send(input logic [MW-1:0] m,
                      input logic h,
                      input logic [TW-1:0] o,
                      input logic [TW-1:0] r,
                      input bit lt);
    bit ok = 0;
    in_valid = 1;
    in_msg   = m;
    in_hold  = h;
    in_old   = o;
    tok_res  = r;
    tok_late = lt;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    tok_late = 0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (q.size() == 0) ok = 1;
    end
    if (!ok) chk("drain_timeout", q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    in_valid = 0;
    in_msg = '0;
    in_hold = 0;
    in_old = '0;
    out_ready = 1;
    tok_res = '0;
    tok_late = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_align_err", align_err, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1;

    send({64{8'hA5}}, 0, '0,
         {32'h0001_0000, 32'h0002_0000}, 0);
    drain();

    peak = 0;
    for (int i = 0; i < 64; i++)
      send(MW'(i), 0, TW'(rnd_msg()), TW'(rnd_msg()), 0);
    drain();
    chk("peak_inflight", peak, L + 1);

    send(rnd_msg(), 1, {32'h11, 32'h22},
         {32'h33, 32'h44}, 0);
    send(rnd_msg(), 0, {32'h11, 32'h22},
         {32'h33, 32'h44}, 0);
    drain();

    st0 = stalls;
    fork
      for (int i = 0; i < 10; i++)
        send(MW'(100 + i), 1'($urandom),
             TW'(rnd_msg()), TW'(rnd_msg()), 0);
      begin
        repeat (L + 1) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 0;
        repeat (5) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1;
      end
    join
    drain();
    chk("stall_cycles", stalls - st0, 5);

    rnd_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      send(rnd_msg(), 1'($urandom),
           TW'(rnd_msg()), TW'(rnd_msg()), 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_rdy = 0;
    out_ready = 1;
    drain();

    chk("align_err_pre", align_err, 0);
    send(rnd_msg(), 0, TW'(rnd_msg()), TW'(rnd_msg()), 1);
    drain();
    chk("align_err_set", align_err, 1);
    for (int i = 0; i < 3; i++)
      send(rnd_msg(), 0, TW'(rnd_msg()), TW'(rnd_msg()), 0);
    drain();
    chk("align_err_sticky", align_err, 1);

    for (int i = 0; i < 12; i++)
      send(rnd_msg(), 0, TW'(rnd_msg()), TW'(rnd_msg()), 0);
    chk("pre_rst_inflight", inflight, 12);
    rst_n = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_inflight", inflight, 0);
    chk("mid_rst_align_err", align_err, 0);
    q.delete();
    seen = 0;
    err_exp = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    chk("post_rst_in_ready", in_ready, 1);
    send(rnd_msg(), 1, TW'(rnd_msg()), TW'(rnd_msg()), 0);
    drain();
    chk("final_align_err", align_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
